fsram_drain: RTL and testbench

Read-side unpacker for FSRAM. On a start pulse it walks one feature map stored in FSRAM port B as packed 16-bit pixel pairs. It unpacks each word into single 8-bit pixels and streams them out in raster or serpentine order over a valid/ready handshake. It sits between FSRAM port B and the DRAM write-back path, and inverts the byte-to-word packing done on the FSRAM write side.

---
 rtl/fsram_drain.sv | 185 ++++++++++++++++++
 tb/tb_fsram_drain.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fsram_drain.sv
`default_nettype none
// ============================================================================
// Module   : fsram_drain
// Purpose  : Reads one feature map from FSRAM port B and streams its packed
//            pixel pairs out as single 8-bit pixels, raster or serpentine.
// Revision : 1.0 - initial release
// ============================================================================
module fsram_drain #(
  parameter int ROW = 16,
  parameter int COL = 256,
  parameter int AW  = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          serp,
  output logic          CENB,
  output logic [AW-1:0] AB,
  input  logic [15:0]   QB,
  output logic [7:0]    pix_out,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_last_col,
  output logic          busy,
  output logic          done
);

  localparam int HALF = COL / 2;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [KW-1:0] c_k_last   = KW'(HALF - 1);
  localparam logic [RW-1:0] c_row_last = RW'(ROW - 1);
  localparam logic [AW-1:0] c_half     = AW'(HALF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_serp;
  logic [RW-1:0]   r_row;
  logic [KW-1:0]   r_k;
  logic [AW-1:0]   r_ab;
  logic            r_inflight;
  logic            r_inf_rev;
  logic            r_inf_last;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_issue;

  // Two-entry word buffer; each entry carries its row direction and row-end flag
  logic [15:0]     r_mem_data [2];
  logic            r_mem_rev  [2];
  logic            r_mem_last [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_cnt;
  logic            r_bsel;

  logic            w_valid;
  logic            w_hs;
  logic            w_pop;
  logic            w_rev_row;
  logic            w_row_end;
  logic            w_last_row;
  logic            w_room;
  logic [AW-1:0]   w_addr;
  logic [15:0]     w_head;
  logic [7:0]      w_first;
  logic [7:0]      w_second;

  assign w_valid    = (r_cnt != 2'd0);
  assign w_hs       = w_valid & pix_ready;
  assign w_pop      = w_hs & r_bsel;
  assign w_rev_row  = r_serp & r_row[0];
  assign w_row_end  = w_rev_row ? (r_k == '0) : (r_k == c_k_last);
  assign w_last_row = (r_row == c_row_last);
  assign w_addr     = AW'(r_row) * c_half + AW'(r_k);
  // Post-pop occupancy plus the read whose data lands at the next edge
  assign w_room     = (({1'b0, r_cnt} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ: begin
        w_issue = w_room;
        if (w_room && w_row_end && w_last_row) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && (r_cnt == 2'd1) && !r_inflight) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_serp     <= 1'b0;
      r_row      <= '0;
      r_k        <= '0;
      r_ab       <= '0;
      r_inflight <= 1'b0;
      r_inf_rev  <= 1'b0;
      r_inf_last <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= w_done_nxt;
      r_inflight <= w_issue;
      r_inf_rev  <= w_rev_row;
      r_inf_last <= w_row_end;
      if (r_state == S_IDLE && start) begin
        r_serp <= serp;
        r_row  <= '0;
        r_k    <= '0;
      end else if (w_issue) begin
        r_ab <= w_addr;
        if (w_row_end) begin
          if (!w_last_row) begin
            r_row <= r_row + RW'(1);
            // The next row runs reversed when serpentine and the current row is even
            r_k   <= (r_serp & ~r_row[0]) ? c_k_last : '0;
          end
        end else begin
          r_k <= w_rev_row ? (r_k - KW'(1)) : (r_k + KW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_data[i] <= '0;
        r_mem_rev[i]  <= 1'b0;
        r_mem_last[i] <= 1'b0;
      end
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      r_bsel <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_mem_data[r_wptr] <= QB;
        r_mem_rev[r_wptr]  <= r_inf_rev;
        r_mem_last[r_wptr] <= r_inf_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_bsel <= 1'b0;
      end else if (w_hs) begin
        r_bsel <= 1'b1;
      end
      r_cnt <= (r_cnt + {1'b0, r_inflight}) - {1'b0, w_pop};
    end
  end

  assign w_head   = r_mem_data[r_rptr];
  assign w_first  = r_mem_rev[r_rptr] ? w_head[7:0]  : w_head[15:8];
  assign w_second = r_mem_rev[r_rptr] ? w_head[15:8] : w_head[7:0];

  assign CENB         = ~w_issue;
  assign AB           = w_issue ? w_addr : r_ab;
  assign pix_valid    = w_valid;
  assign pix_out      = !w_valid ? 8'h00 : (r_bsel ? w_second : w_first);
  assign pix_last_col = w_valid & r_mem_last[r_rptr] & r_bsel;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fsram_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsram_drain
// Purpose  : Randomized self-checking bench for fsram_drain against a
//            pixel-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsram_drain;

  localparam int ROW = 4;
  localparam int COL = 8;
  localparam int AW  = 4;
  localparam int NW  = ROW * COL / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          serp;
  logic          CENB;
  logic [AW-1:0] AB;
  logic [15:0]   QB;
  logic [7:0]    pix_out;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last_col;
  logic          busy;
  logic          done;

  logic [15:0]   mem [NW];
  int            n_cmp = 0;
  int            n_bad = 0;

  fsram_drain #(.ROW(ROW), .COL(COL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .serp(serp),
    .CENB(CENB), .AB(AB), .QB(QB),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last_col(pix_last_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous FSRAM model; junk on QB whenever no read was issued
  always @(posedge clk) QB <= !CENB ? mem[AB] : 16'($urandom);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready=1, 1 ready toggles, 2 ready low 20 cycles after first valid, 3 random
  task automatic run_frame(input bit sp, input int mode, input bit poke5, input bit chain,
                           input bit prestarted, input int abort_at);
    logic [7:0] ep[$];
    bit         el[$];
    int         ea[$];
    logic [7:0] got[$];
    bit         gl[$];
    int         addrs[$];
    int         fv = -1, first_hs = -1, last_hs = -1, nreads = 0, hs = 0, maxo = 0;
    bit         fin = 1'b0, unstable = 1'b0;
    logic [7:0] hold_pix = 8'h00;
    logic [31:0] g;

    for (int r = 0; r < ROW; r++) begin
      for (int j = 0; j < COL; j++) begin
        int c, a;
        c = (sp && (r % 2 == 1)) ? COL - 1 - j : j;
        a = r * (COL / 2) + c / 2;
        ep.push_back((c % 2 == 0) ? mem[a][15:8] : mem[a][7:0]);
        el.push_back(j == COL - 1);
        if (j % 2 == 0) ea.push_back(a);
      end
    end

    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1;
      serp  = sp;
    end

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      serp  = 1'($urandom);
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 2 == 0);
        2:       pix_ready = (fv >= 0 && cyc >= fv + 20);
        default: pix_ready = 1'($urandom);
      endcase
      if (poke5 && hs == 5) start = 1'b1;
      #1;
      if (cyc == 0) check_val("start_resp", {busy, CENB, AB}, {1'b1, 1'b0, {AW{1'b0}}});
      if (!CENB) begin
        addrs.push_back(int'(AB));
        nreads++;
      end
      if (pix_valid && fv < 0) begin
        fv = cyc;
        hold_pix = pix_out;
        check_val("first_valid_cyc", cyc, 2);
      end
      if (mode == 2 && fv >= 0 && cyc < fv + 20) begin
        if (pix_out !== hold_pix || !pix_valid) unstable = 1'b1;
        if (cyc == fv + 19) begin
          check_val("hold_reads", nreads, 2);
          check_val("hold_stable", unstable, 0);
          check_val("hold_pix", pix_out, ep[0]);
        end
      end
      if (pix_valid && pix_ready) begin
        got.push_back(pix_out);
        gl.push_back(pix_last_col);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        hs++;
      end
      if (nreads - hs / 2 > maxo) maxo = nreads - hs / 2;
      if (abort_at >= 0 && hs == abort_at) return;
      if (done) begin
        fin = 1'b1;
        check_val("done_delay", cyc - last_hs, 1);
        check_val("busy_at_done", busy, 0);
        if (chain) begin
          start = 1'b1;
          serp  = sp;
        end
      end
    end

    if (!fin) check_val("timeout", 0, 1);
    check_val("npix", got.size(), ep.size());
    foreach (ep[i]) begin
      g = 'x;
      if (i < got.size()) g = 32'(got[i]);
      check_val($sformatf("pix%0d", i), g, 32'(ep[i]));
      g = 'x;
      if (i < gl.size()) g = 32'(gl[i]);
      check_val($sformatf("last%0d", i), g, 32'(el[i]));
    end
    check_val("nreads", nreads, NW);
    foreach (ea[i]) begin
      g = 'x;
      if (i < addrs.size()) g = addrs[i];
      check_val($sformatf("addr%0d", i), g, ea[i]);
    end
    check_val("outstanding_le2", (maxo <= 2), 1);
    if (mode == 0) check_val("no_bubbles", last_hs - first_hs, ep.size() - 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; serp = 1'b0; pix_ready = 1'b0;
    for (int a = 0; a < NW; a++) mem[a] = {8'(2 * a), 8'(2 * a + 1)};
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outs", {CENB, AB, pix_out, pix_valid, pix_last_col, busy, done},
              {1'b1, {AW{1'b0}}, 8'h00, 4'b0000});
    @(negedge clk);
    rst = 1'b0;

    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b0, 0, 1'b1, 1'b1, 1'b0, -1);
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b1, -1);

    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < NW; a++) mem[a] = 16'($urandom);
      run_frame(1'b1, 3, 1'b0, 1'b0, 1'b0, -1);
    end
    run_frame(1'b0, 3, 1'b0, 1'b0, 1'b0, -1);

    // Asynchronous reset in the middle of a clock cycle while pixel 10 is presented
    for (int a = 0; a < NW; a++) mem[a] = {8'(2 * a), 8'(2 * a + 1)};
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, 10);
    #2 rst = 1'b1;
    #1;
    check_val("async_reset_outs", {CENB, AB, pix_out, pix_valid, pix_last_col, busy, done},
              {1'b1, {AW{1'b0}}, 8'h00, 4'b0000});
    @(negedge clk);
    rst = 1'b0;
    pix_ready = 1'b0;
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
